// File: rtl/lfsr_prbs_sync_check.sv
// lfsr_prbs_sync_check: self-synchronising PRBS checker with HUNT/LOCKED tracking and saturating BER counters.
// Define LFSR_PRBS_SYNC_CHECK_WORD_COUNT_EN to add the word_count output.
module lfsr #(
  parameter int LFSR_WIDTH = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = 31'h10000001,
  parameter bit LFSR_FEED_FORWARD = 0,
  parameter bit REVERSE = 0,
  parameter int DATA_WIDTH = 8,
  parameter string STYLE = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);
  localparam logic [LFSR_WIDTH-1:0] TAPS = {1'b1, LFSR_POLY[LFSR_WIDTH-1:1]};
  logic [LFSR_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] d, o;
  logic fb;
  always_comb begin
    for (int i = 0; i < LFSR_WIDTH; i++) s[i] = REVERSE ? state_in[LFSR_WIDTH-1-i] : state_in[i];
    for (int i = 0; i < DATA_WIDTH; i++) d[i] = REVERSE ? data_in[DATA_WIDTH-1-i] : data_in[i];
    o = '0;
    fb = 1'b0;
    // Fibonacci, MSB of the word first; feed-forward shifts the input bit itself into the state
    for (int i = DATA_WIDTH-1; i >= 0; i--) begin
      if (STYLE == "REDUCTION") fb = ^(s & TAPS);
      else begin
        fb = s[LFSR_WIDTH-1];
        for (int j = 1; j < LFSR_WIDTH; j++) if (LFSR_POLY[j]) fb = fb ^ s[j-1];
      end
      o = (o << 1) | DATA_WIDTH'(fb ^ d[i]);
      s = (s << 1) | LFSR_WIDTH'(LFSR_FEED_FORWARD ? d[i] : fb ^ d[i]);
    end
    for (int i = 0; i < LFSR_WIDTH; i++) state_out[i] = REVERSE ? s[LFSR_WIDTH-1-i] : s[i];
    for (int i = 0; i < DATA_WIDTH; i++) data_out[i] = REVERSE ? o[DATA_WIDTH-1-i] : o[i];
  end
endmodule

module lfsr_prbs_sync_check #(
  parameter int LFSR_WIDTH = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = 31'h10000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT = '1,
  parameter bit REVERSE = 0,
  parameter bit INVERT = 1,
  parameter int DATA_WIDTH = 8,
  parameter string STYLE = "AUTO",
  parameter int LOCK_COUNT = 4,
  parameter int UNLOCK_COUNT = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic data_valid,
  input  logic count_clear,
  output logic locked,
  output logic error_valid,
  output logic [$clog2(DATA_WIDTH+1)-1:0] error_bits,
  output logic [COUNT_WIDTH-1:0] error_count
`ifdef LFSR_PRBS_SYNC_CHECK_WORD_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] word_count
`endif
);
  localparam int EB = $clog2(DATA_WIDTH+1);
  localparam int GW = $clog2(LOCK_COUNT+1);
  localparam int BW = $clog2(UNLOCK_COUNT+1);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t st_q;
  logic [LFSR_WIDTH-1:0] lfsr_q, s_free, s_seed;
  logic [DATA_WIDTH-1:0] d, p, unused_seed_data;
  logic [EB-1:0] err_n;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [COUNT_WIDTH-1:0] cnt_d;
  logic counted;
  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a, input logic [EB-1:0] b);
    logic [COUNT_WIDTH+EB-1:0] s;
    s = (COUNT_WIDTH+EB)'(a) + (COUNT_WIDTH+EB)'(b);
    return |s[COUNT_WIDTH+EB-1:COUNT_WIDTH] ? '1 : s[COUNT_WIDTH-1:0];
  endfunction
  assign d = INVERT ? ~data_in : data_in;
  lfsr #(.LFSR_WIDTH(LFSR_WIDTH), .LFSR_POLY(LFSR_POLY), .LFSR_FEED_FORWARD(0), .REVERSE(REVERSE),
    .DATA_WIDTH(DATA_WIDTH), .STYLE(STYLE)) u_pred (
    .data_in({DATA_WIDTH{1'b0}}), .state_in(lfsr_q), .data_out(p), .state_out(s_free));
  lfsr #(.LFSR_WIDTH(LFSR_WIDTH), .LFSR_POLY(LFSR_POLY), .LFSR_FEED_FORWARD(1), .REVERSE(REVERSE),
    .DATA_WIDTH(DATA_WIDTH), .STYLE(STYLE)) u_seed (
    .data_in(d), .state_in(lfsr_q), .data_out(unused_seed_data), .state_out(s_seed));
  assign err_n = EB'($countones(d ^ p));
  assign counted = data_valid && st_q == LOCKED;
  assign locked = st_q == LOCKED;
  assign good_d = err_n != '0 ? '0 : good_q + 1'b1;
  assign bad_d = err_n != '0 ? bad_q + 1'b1 : '0;
  assign cnt_d = sat_add(count_clear ? '0 : error_count, counted ? err_n : '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= HUNT;
      lfsr_q <= LFSR_INIT;
      good_q <= '0;
      bad_q <= '0;
      error_valid <= 1'b0;
      error_bits <= '0;
      error_count <= '0;
    end else begin
      error_valid <= data_valid;
      if (count_clear || counted) error_count <= cnt_d;
      if (data_valid) begin
        error_bits <= err_n;
        if (st_q == HUNT) begin
          lfsr_q <= s_seed;
          good_q <= good_d;
          if (good_d == GW'(LOCK_COUNT)) begin
            st_q <= LOCKED;
            bad_q <= '0;
          end
        end else begin
          // free-run so corrupted words never reach the local state
          lfsr_q <= s_free;
          bad_q <= bad_d;
          if (bad_d == BW'(UNLOCK_COUNT)) begin
            st_q <= HUNT;
            good_q <= '0;
          end
        end
      end
    end
  end
`ifdef LFSR_PRBS_SYNC_CHECK_WORD_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) word_count <= '0;
    else if (count_clear || counted) word_count <= sat_add(count_clear ? '0 : word_count, EB'(counted));
  end
`endif
endmodule
